adc_sample_sequencer: RTL and testbench

- Master-side sequencer for the external 12-bit serial ADC: generates CS and SCLK from the system clock at a fixed sample rate and shifts in the 16-bit frame.
- Converts each frame's 12-bit offset-binary result to two's complement and presents it to the downstream audio/filter datapath over a valid/ready handshake.
- Sits between the ADC pins and the processing chain.
- Single clock domain: SCLK is a registered output, never a clock.

---
 rtl/adc_sample_sequencer_if.sv | 10 +
 rtl/adc_sample_sequencer.sv | 161 ++++++++++++++++
 tb/tb_adc_sample_sequencer.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_sample_sequencer_if.sv
// Sample stream from the ADC sequencer to the processing chain.
// valid/ready handshake: a sample transfers when data_valid & data_ready.
interface adc_sample_sequencer_if;
    logic [11:0] data_out;
    logic        data_valid;
    logic        data_ready;

    modport master (output data_out, output data_valid, input data_ready);
    modport slave  (input data_out, input data_valid, output data_ready);
endinterface

// File: rtl/adc_sample_sequencer.sv
// Serial ADC master: periodic CS/SCLK frames, 16-bit shift-in, offset-binary to two's complement.
// Sample appears 34*CLK_DIV cycles after CS falls; an unaccepted sample is overwritten and flags sticky overrun.
module adc_sample_sequencer #(
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 2272,
    parameter int QUIET_CYCLES  = 2
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_enable,
    input  logic                          i_sdata,
    output logic                          o_cs,
    output logic                          o_sclk,
    output logic                          o_busy,
    output logic                          o_overrun,
    adc_sample_sequencer_if.master        sample_if
);

    localparam int CMAX = (CLK_DIV > QUIET_CYCLES) ? CLK_DIV : QUIET_CYCLES;
    localparam int CW   = $clog2(CMAX);
    localparam int PW   = $clog2(SAMPLE_PERIOD);

    localparam logic [CW-1:0] DIV_LAST    = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] QUIET_LAST  = CW'(QUIET_CYCLES - 1);
    localparam logic [PW-1:0] PERIOD_LAST = PW'(SAMPLE_PERIOD - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_SHIFT,
        S_TRAIL,
        S_QUIET
    } state_t;

    state_t        r_state;
    logic [PW-1:0] r_period_cnt;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_bit_cnt;
    logic [11:0]   r_shift;
    logic          r_cs;
    logic          r_sclk;
    logic          r_busy;
    logic [11:0]   r_data_out;
    logic          r_data_valid;
    logic          r_overrun;

    logic          w_tick;
    logic          w_div_done;
    logic          w_accept;

    assign w_tick     = i_enable & (r_period_cnt == '0);
    assign w_div_done = (r_cnt == DIV_LAST);
    assign w_accept   = r_data_valid & sample_if.data_ready;

    always_ff @(posedge i_clk) begin
        if (i_reset || !i_enable) begin
            r_period_cnt <= '0;
        end else if (r_period_cnt == PERIOD_LAST) begin
            r_period_cnt <= '0;
        end else begin
            r_period_cnt <= r_period_cnt + PW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_cs         <= 1'b1;
            r_sclk       <= 1'b1;
            r_busy       <= 1'b0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_data_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_tick) begin
                        r_cs    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_LEAD;
                    end
                end

                S_LEAD: begin
                    if (w_div_done) begin
                        r_cnt     <= '0;
                        r_sclk    <= 1'b0;
                        r_bit_cnt <= '0;
                        r_state   <= S_SHIFT;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                // r_sclk doubles as the half-period phase; capture on the rising transition.
                // Only 12 bits are kept: the four leading zeros shift out the top.
                S_SHIFT: begin
                    if (w_div_done) begin
                        r_cnt <= '0;
                        if (!r_sclk) begin
                            r_sclk  <= 1'b1;
                            r_shift <= {r_shift[10:0], i_sdata};
                        end else if (r_bit_cnt == 4'd15) begin
                            r_state <= S_TRAIL;
                        end else begin
                            r_sclk    <= 1'b0;
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                S_TRAIL: begin
                    if (w_div_done) begin
                        r_cnt        <= '0;
                        r_cs         <= 1'b1;
                        r_state      <= S_QUIET;
                        r_data_out   <= {~r_shift[11], r_shift[10:0]};
                        r_data_valid <= 1'b1;
                        if (r_data_valid && !sample_if.data_ready) begin
                            r_overrun <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                S_QUIET: begin
                    if (r_cnt == QUIET_LAST) begin
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_cs                 = r_cs;
    assign o_sclk               = r_sclk;
    assign o_busy               = r_busy;
    assign o_overrun            = r_overrun;
    assign sample_if.data_out   = r_data_out;
    assign sample_if.data_valid = r_data_valid;

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// Directed bench for adc_sample_sequencer with a behavioural serial ADC model.
// Frame timing, conversion, handshake, overrun, enable drop and mid-frame reset.
`timescale 1ns/1ps
module tb_adc_sample_sequencer;

    localparam int CLK_DIV       = 2;
    localparam int SAMPLE_PERIOD = 100;
    localparam int QUIET_CYCLES  = 2;

    logic clk = 1'b0;
    logic reset;
    logic enable;
    logic sdata;
    logic cs;
    logic sclk;
    logic busy;
    logic overrun;

    adc_sample_sequencer_if sif();

    adc_sample_sequencer #(
        .CLK_DIV       (CLK_DIV),
        .SAMPLE_PERIOD (SAMPLE_PERIOD),
        .QUIET_CYCLES  (QUIET_CYCLES)
    ) dut (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_enable  (enable),
        .i_sdata   (sdata),
        .o_cs      (cs),
        .o_sclk    (sclk),
        .o_busy    (busy),
        .o_overrun (overrun),
        .sample_if (sif)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ADC model: shifts the frame out MSB first, updating after each SCLK fall.
    logic [15:0] frame = '0;
    int          bit_idx = 0;
    initial sdata = 1'b0;
    always @(negedge cs) bit_idx = 15;
    always @(negedge sclk) begin
        if (!cs && bit_idx >= 0) begin
            sdata   = frame[bit_idx];
            bit_idx = bit_idx - 1;
        end
    end

    // Pin monitor
    logic prev_cs = 1'b1, prev_sclk = 1'b1, prev_busy = 1'b0;
    int cs_fall_cyc = 0, fall_gap = 0, n_falls = 0, cs_low_len = 0, frames_done = 0;
    int sclk_rises = 0, last_rise = 0, gap_bad = 0, busy_start = 0, busy_len = 0;
    always @(negedge clk) begin
        if (prev_cs && !cs) begin
            if (n_falls > 0) fall_gap = cyc - cs_fall_cyc;
            cs_fall_cyc = cyc;
            n_falls     = n_falls + 1;
            sclk_rises  = 0;
            gap_bad     = 0;
        end
        if (!prev_cs && cs) begin
            cs_low_len  = cyc - cs_fall_cyc;
            frames_done = frames_done + 1;
        end
        if (!cs && !prev_sclk && sclk) begin
            if (sclk_rises > 0 && (cyc - last_rise) != 2 * CLK_DIV) gap_bad = gap_bad + 1;
            last_rise  = cyc;
            sclk_rises = sclk_rises + 1;
        end
        if (!prev_busy && busy) busy_start = cyc;
        if (prev_busy && !busy) busy_len = cyc - busy_start;
        prev_cs   = cs;
        prev_sclk = sclk;
        prev_busy = busy;
    end

    int n_checks = 0;
    int n_pass   = 0;
    int en_cyc   = 0;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    task automatic set_enable();
        @(posedge clk);
        #1;
        enable = 1'b1;
        en_cyc = cyc;
    endtask

    task automatic wait_frame(input int budget);
        int start;
        int n;
        start = frames_done;
        n = 0;
        while (frames_done == start && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (frames_done == start) chk_eq("frame_timeout", 0, 1);
    endtask

    task automatic wait_rises(input int target, input int budget);
        int start;
        int n;
        start = n_falls;
        n = 0;
        while (!(n_falls > start && sclk_rises >= target) && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!(n_falls > start && sclk_rises >= target)) chk_eq("rise_timeout", 0, 1);
    endtask

    initial begin
        int lcyc;
        int nf;
        int n;
        reset          = 1'b1;
        enable         = 1'b0;
        sif.data_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_eq("rst_cs", cs, 1);
        chk_eq("rst_sclk", sclk, 1);
        chk_eq("rst_data", sif.data_out, 0);
        chk_eq("rst_valid", sif.data_valid, 0);
        chk_eq("rst_busy", busy, 0);
        chk_eq("rst_overrun", overrun, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // First frame after enable
        frame = 16'h0A55;
        set_enable();
        wait_frame(200);
        chk_eq("t1_cs_lat", cs_fall_cyc - en_cyc, 1);
        chk_eq("t1_rises", sclk_rises, 16);
        chk_eq("t1_rise_gap", gap_bad, 0);
        chk_eq("t1_cs_low", cs_low_len, 68);
        chk_eq("t1_data", sif.data_out, 12'h255);
        chk_eq("t1_valid", sif.data_valid, 1);
        repeat (3) @(negedge clk);
        chk_eq("t1_busy_len", busy_len, 70);
        chk_eq("t1_busy_idle", busy, 0);

        // Extremes with ready held high
        sif.data_ready = 1'b1;
        frame = 16'h0800;
        repeat (2) @(negedge clk);
        chk_eq("t2_accept", sif.data_valid, 0);
        wait_frame(200);
        chk_eq("t2_data_min", sif.data_out, 12'h000);
        chk_eq("t2_valid_a", sif.data_valid, 1);
        chk_eq("t2_period_a", fall_gap, 100);
        @(negedge clk);
        chk_eq("t2_pulse_a", sif.data_valid, 0);
        frame = 16'h07FF;
        wait_frame(200);
        chk_eq("t2_data_max", sif.data_out, 12'hFFF);
        chk_eq("t2_valid_b", sif.data_valid, 1);
        chk_eq("t2_period_b", fall_gap, 100);
        @(negedge clk);
        chk_eq("t2_pulse_b", sif.data_valid, 0);

        // Overrun with ready low over two frames
        sif.data_ready = 1'b0;
        frame = 16'h0123;
        wait_frame(200);
        chk_eq("t3_data_a", sif.data_out, 12'h923);
        chk_eq("t3_ovr_a", overrun, 0);
        frame = 16'h0FFF;
        wait_frame(200);
        chk_eq("t3_data_b", sif.data_out, 12'h7FF);
        chk_eq("t3_valid_b", sif.data_valid, 1);
        chk_eq("t3_ovr_b", overrun, 1);
        sif.data_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk_eq("t3_accept", sif.data_valid, 0);
        chk_eq("t3_ovr_sticky", overrun, 1);

        // Accept in the exact load cycle
        enable = 1'b0;
        reset  = 1'b1;
        repeat (2) @(negedge clk);
        chk_eq("rst2_overrun", overrun, 0);
        chk_eq("rst2_data", sif.data_out, 0);
        reset = 1'b0;
        sif.data_ready = 1'b0;
        frame = 16'h0456;
        set_enable();
        wait_frame(200);
        chk_eq("t4_data_a", sif.data_out, 12'hC56);
        frame = 16'h0AAA;
        lcyc = cs_fall_cyc + SAMPLE_PERIOD + 68;
        n = 0;
        while (cyc != lcyc - 1 && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        sif.data_ready = 1'b1;
        @(negedge clk);
        #1;
        sif.data_ready = 1'b0;
        chk_eq("t4_data_b", sif.data_out, 12'h2AA);
        chk_eq("t4_valid", sif.data_valid, 1);
        chk_eq("t4_ovr", overrun, 0);
        @(negedge clk);
        chk_eq("t4_valid_hold", sif.data_valid, 1);

        // Enable dropped mid-frame
        sif.data_ready = 1'b1;
        frame = 16'h0321;
        wait_rises(8, 300);
        enable = 1'b0;
        wait_frame(200);
        chk_eq("t5_data", sif.data_out, 12'hB21);
        chk_eq("t5_rises", sclk_rises, 16);
        chk_eq("t5_cs_low", cs_low_len, 68);
        nf = n_falls;
        repeat (250) @(negedge clk);
        chk_eq("t5_no_tick", n_falls, nf);
        chk_eq("t5_cs_idle", cs, 1);
        sif.data_ready = 1'b0;
        frame = 16'h0ABC;
        set_enable();
        wait_frame(200);
        chk_eq("t5_reen_lat", cs_fall_cyc - en_cyc, 1);
        chk_eq("t5_reen_data", sif.data_out, 12'h2BC);

        // Reset mid-frame
        frame = 16'h0FFF;
        wait_rises(10, 300);
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk_eq("t6_cs", cs, 1);
        chk_eq("t6_sclk", sclk, 1);
        chk_eq("t6_busy", busy, 0);
        chk_eq("t6_valid", sif.data_valid, 0);
        frame = 16'h0135;
        reset = 1'b0;
        wait_frame(200);
        chk_eq("t6_data", sif.data_out, 12'h935);
        chk_eq("t6_valid_new", sif.data_valid, 1);
        chk_eq("t6_rises", sclk_rises, 16);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
